// File: rtl/multiplier_pkg.sv
// rtl/multiplier_pkg.sv - shared state encoding and sizing helper for the shift-add multiplier
package multiplier_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4,
    ITER  = 3'd5
  } mult_state_t;

  // Counter must reach WIDTH itself, hence WIDTH+1 distinct values.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/multiplier_nbit_if.sv
// rtl/multiplier_nbit_if.sv - switch/button side controls and register/status outputs of the multiplier
interface multiplier_nbit_if #(
  parameter int WIDTH = 8
);
  logic             ClearA_LoadB;
  logic             Run;
  logic [WIDTH-1:0] S;
  logic [WIDTH-1:0] Aval;
  logic [WIDTH-1:0] Bval;
  logic             X;
  logic             M;
  logic             Busy;
  logic             Done;

  modport master (
    output ClearA_LoadB, Run, S,
    input  Aval, Bval, X, M, Busy, Done
  );

  modport slave (
    input  ClearA_LoadB, Run, S,
    output Aval, Bval, X, M, Busy, Done
  );
endinterface

// File: rtl/add_sub_nbit.sv
// rtl/add_sub_nbit.sv - (WIDTH+1)-bit sign-extending adder/subtractor producing {X, sum}
module add_sub_nbit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] s_i,
  input  logic             sub_i,
  output logic             x_o,
  output logic [WIDTH-1:0] sum_o
);

  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] s_ext;

  assign a_ext = {a_i[WIDTH-1], a_i};
  assign s_ext = {s_i[WIDTH-1], s_i};

  // Result wraps modulo 2^(WIDTH+1); the top bit becomes the new X.
  assign {x_o, sum_o} = sub_i ? (a_ext - s_ext) : (a_ext + s_ext);

endmodule

// File: rtl/multiplier_nbit.sv
// rtl/multiplier_nbit.sv - signed shift-add multiplier, X:A:B product chain; MULT_FAST_ITER_EN merges ADD/SHIFT into ITER
module multiplier_nbit
  import multiplier_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  multiplier_nbit_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  mult_state_t      state_q;
  logic             x_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;

  logic             sub_d;
  logic             x_sum;
  logic [WIDTH-1:0] a_sum;
  logic [WIDTH:0]   xa_d;

  // The sign bit of B carries negative weight, so the final step subtracts.
  assign sub_d = (cnt_q == LAST_CNT);

  add_sub_nbit #(.WIDTH(WIDTH)) u_add_sub (
    .a_i   (a_q),
    .s_i   (bus.S),
    .sub_i (sub_d),
    .x_o   (x_sum),
    .sum_o (a_sum)
  );

  assign xa_d = b_q[0] ? {x_sum, a_sum} : {x_q, a_q};

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      x_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.ClearA_LoadB) begin
            x_q <= 1'b0;
            a_q <= '0;
            b_q <= bus.S;
          end else if (bus.Run) begin
            state_q <= CLR;
            busy_q  <= 1'b1;
          end
        end
        CLR: begin
          x_q   <= 1'b0;
          a_q   <= '0;
          cnt_q <= '0;
`ifdef MULT_FAST_ITER_EN
          state_q <= ITER;
`else
          state_q <= ADD;
`endif
        end
`ifdef MULT_FAST_ITER_EN
        ITER: begin
          x_q   <= xa_d[WIDTH];
          a_q   <= xa_d[WIDTH:1];
          b_q   <= {xa_d[0], b_q[WIDTH-1:1]};
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
`else
        ADD: begin
          {x_q, a_q} <= xa_d;
          state_q    <= SHIFT;
        end
        SHIFT: begin
          a_q   <= {x_q, a_q[WIDTH-1:1]};
          b_q   <= {a_q[0], b_q[WIDTH-1:1]};
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= ADD;
          end
        end
`endif
        DONE: begin
          if (!bus.Run) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Aval = a_q;
  assign bus.Bval = b_q;
  assign bus.X    = x_q;
  assign bus.M    = b_q[0];
  assign bus.Busy = busy_q;
  assign bus.Done = done_q;

endmodule
